mealy1010_overlapping: RTL and testbench

- Serial bit-pattern detector, Mealy style, one input bit per clock.
- Default configuration detects the sequence 1-0-1-0 with overlap allowed.
- Output c pulses high, combinationally, in the same cycle the final pattern bit is present on a.
- Used as a leaf block on a serial data stream. No handshake; every rising clk edge consumes one bit.

---
 rtl/mealy1010_overlapping.sv | 90 +++++++++
 tb/tb_mealy1010_overlapping.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mealy1010_overlapping.sv
// Serial pattern detector, Mealy style, one input bit per rising clk edge.
// The FSM state is the length of the currently matched pattern prefix.
// The next-state table is built once at elaboration using the KMP
// failure rule, so the runtime logic is only a table lookup.
// The output c is combinational from the state and the current input bit.
// The port "state" exposes the matched-prefix length for observation.
module mealy1010_overlapping #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       a,
    output logic                       c,
    output logic [$clog2(PAT_LEN)-1:0] state
);

    localparam int W     = $clog2(PAT_LEN);
    localparam int TBL_N = 1 << W;

    // S0 is the empty match. S_LAST means all bits but the final one are
    // matched. For the default 1010 pattern, the states are
    // S0 = none, S1 = "1", S2 = "10", S3 = "101".
    localparam logic [W-1:0] S0     = '0;
    localparam logic [W-1:0] S_LAST = W'(PAT_LEN - 1);

    // Build the next-state table for one input bit value.
    // Entry m is the new matched length after bit b arrives in state m.
    // The new length is the longest suffix of (prefix[0..m-1], b) that is also a
    // pattern prefix, capped at PAT_LEN-1 so that a full match falls back to
    // its failure length.
    // A full match restarts at S0 when overlap is off.
    // Encodings at or above PAT_LEN return to S0.
    function automatic logic [TBL_N*W-1:0] build_table(input logic b);
        logic [TBL_N*W-1:0] t;
        t = '0;
        for (int m = 0; m < PAT_LEN; m++) begin
            int best;
            int kmax;
            best = 0;
            kmax = (m + 1 < PAT_LEN - 1) ? m + 1 : PAT_LEN - 1;
            for (int k = 1; k <= kmax; k++) begin
                bit ok;
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    int   j;
                    logic sc;
                    logic pc;
                    j  = m + 1 - k + i;
                    sc = (j == m) ? b : PATTERN[PAT_LEN-1-j];
                    pc = PATTERN[PAT_LEN-1-i];
                    if (sc != pc) ok = 1'b0;
                end
                if (ok) best = k;
            end
            if (!OVERLAP && (m == PAT_LEN - 1) && (b == PATTERN[0])) best = 0;
            t[m*W +: W] = W'(best);
        end
        return t;
    endfunction

    localparam logic [TBL_N*W-1:0] NXT0 = build_table(1'b0);
    localparam logic [TBL_N*W-1:0] NXT1 = build_table(1'b1);

    logic [W-1:0] m_q;
    logic [W-1:0] m_nxt;

    // Look up the next matched length for the current state and input bit.
    always_comb begin
        m_nxt = S0;
        if (a) m_nxt = NXT1[int'(m_q)*W +: W];
        else   m_nxt = NXT0[int'(m_q)*W +: W];
    end

    // Drive the Mealy match flag. It is held low while reset is high.
    always_comb begin
        c = 1'b0;
        if (!reset && (m_q == S_LAST) && (a == PATTERN[0])) c = 1'b1;
    end

    // Update the state register. Reset discards any partial match.
    always_ff @(posedge clk) begin
        if (reset) m_q <= S0;
        else       m_q <= m_nxt;
    end

    assign state = m_q;

endmodule

// File: tb/tb_mealy1010_overlapping.sv
// Testbench for mealy1010_overlapping.
// It runs an overlapping instance and a non-overlapping instance side by side.
// A table of directed vectors is checked first, followed by hand-written
// Mealy-timing sequences and random bits against a bit-history reference model.
module tb_mealy1010_overlapping;

  localparam int PAT_LEN = 4;
  localparam logic [PAT_LEN-1:0] PAT = 4'b1010;

  logic       clk;
  logic       reset;
  logic       a;
  logic       c_ov;
  logic       c_no;
  logic [1:0] state_ov;
  logic [1:0] state_no;

  int checks = 0;
  int errors = 0;

  mealy1010_overlapping #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) dut_ov (
    .clk(clk), .reset(reset), .a(a), .c(c_ov), .state(state_ov)
  );

  mealy1010_overlapping #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) dut_no (
    .clk(clk), .reset(reset), .a(a), .c(c_no), .state(state_no)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The model keeps the bit history since the last restart.
  // A match means the last PAT_LEN-1 stored bits followed by the current bit
  // spell the pattern.
  // The overlapping history is cleared only by reset.
  // The non-overlapping history is also cleared by a match.
  logic hist_ov[$];
  logic hist_no[$];

  function automatic logic window_match(input logic h[$], input logic abit);
    int n;
    n = h.size();
    if (n < PAT_LEN - 1) return 1'b0;
    for (int i = 0; i < PAT_LEN - 1; i++)
      if (h[n-(PAT_LEN-1)+i] != PAT[PAT_LEN-1-i]) return 1'b0;
    return (abit == PAT[0]);
  endfunction

  function automatic logic exp_ov(input logic rst, input logic abit);
    return !rst && window_match(hist_ov, abit);
  endfunction

  function automatic logic exp_no(input logic rst, input logic abit);
    return !rst && window_match(hist_no, abit);
  endfunction

  task automatic model_update(input logic rst, input logic abit);
    logic hit_no;
    hit_no = window_match(hist_no, abit);
    if (rst) begin
      hist_ov.delete();
      hist_no.delete();
    end else begin
      hist_ov.push_back(abit);
      if (hist_ov.size() > PAT_LEN - 1) void'(hist_ov.pop_front());
      if (hit_no) hist_no.delete();
      else begin
        hist_no.push_back(abit);
        if (hist_no.size() > PAT_LEN - 1) void'(hist_no.pop_front());
      end
    end
  endtask

  // ---------------- driver / checker tasks ----------------
  // Inputs change on the falling edge. Outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic abit);
    @(negedge clk);
    reset = rst;
    a     = abit;
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic rst;
    logic a;
    logic c_ov;
    logic c_no;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ab, input logic co, input logic cn);
    vec_t v;
    v.rst = r; v.a = ab; v.c_ov = co; v.c_no = cn;
    vecs.push_back(v);
  endtask

  // Bit i of a sequence is taken MSB-first, from bits[n-1-i].
  task automatic add_seq(input int n, input logic [15:0] bits,
                         input logic [15:0] cov, input logic [15:0] cno);
    for (int i = 0; i < n; i++) add(1'b0, bits[n-1-i], cov[n-1-i], cno[n-1-i]);
  endtask

  initial begin
    reset = 1'b1;
    a     = 1'b0;

    // Reset held for two edges with a=1, then a=0.
    add(1, 1, 0, 0); add(1, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0);
    // Overlap stream.
    add(1, 0, 0, 0);
    add_seq(15, 16'b110101011101111, 16'b000010100000000, 16'b000010000000000);
    // Back-to-back 1010 patterns.
    add(1, 0, 0, 0);
    add_seq(8, 16'b10101010, 16'b00010101, 16'b00010001);
    // Mid-match reset. The reset row presents a=0 in S3, so c must stay 0.
    add(1, 0, 0, 0);
    add_seq(3, 16'b101, 16'b000, 16'b000);
    add(1, 0, 0, 0);
    add(0, 0, 0, 0);
    add_seq(4, 16'b1010, 16'b0001, 16'b0001);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].a);
      check($sformatf("vec%0d_c_ov", i), {1'b0, c_ov}, {1'b0, vecs[i].c_ov});
      check($sformatf("vec%0d_c_no", i), {1'b0, c_no}, {1'b0, vecs[i].c_no});
      if (i == 2) begin
        check("state_after_reset_ov", state_ov, 2'd0);
        check("state_after_reset_no", state_no, 2'd0);
      end
      model_update(vecs[i].rst, vecs[i].a);
    end

    // Mealy timing: reach S3, then toggle a between edges.
    drive(1, 0); model_update(1, 0);
    drive(0, 1); model_update(0, 1);
    drive(0, 0); model_update(0, 0);
    drive(0, 1); model_update(0, 1);
    drive(0, 1);
    check("mealy_a1_c_ov", {1'b0, c_ov}, 2'd0);
    check("mealy_in_s3", state_ov, 2'd3);
    a = 1'b0; #1;
    check("mealy_a0_c_ov", {1'b0, c_ov}, 2'd1);
    check("mealy_a0_c_no", {1'b0, c_no}, 2'd1);
    a = 1'b1; #1;
    check("mealy_a1_again_c_ov", {1'b0, c_ov}, 2'd0);
    check("mealy_state_held", state_ov, 2'd3);
    @(posedge clk); #1;
    check("mealy_s3_a1_to_s1", state_ov, 2'd1);
    model_update(0, 1);

    // Random bits with occasional resets, checked against the model.
    drive(1, 0); model_update(1, 0);
    for (int i = 0; i < 3000; i++) begin
      logic rb;
      logic ab;
      logic eo;
      logic en;
      rb = ($urandom_range(0, 49) == 0);
      ab = 1'($urandom_range(0, 1));
      drive(rb, ab);
      eo = exp_ov(rb, ab);
      en = exp_no(rb, ab);
      check($sformatf("rand%0d_c_ov", i), {1'b0, c_ov}, {1'b0, eo});
      check($sformatf("rand%0d_c_no", i), {1'b0, c_no}, {1'b0, en});
      model_update(rb, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
